nfca_rx_frame: RTL and testbench

- Receive-side framer for ISO14443-A PICC→PCD responses. Sits between the bit demodulator and the byte-level consumer.
- Regroups the demodulated LSB-first bit stream into bytes and checks the odd parity bit after each complete byte.
- Handles a short last byte (e.g. 4-bit ACK/NAK) and a first byte that completes a PCD anticollision split byte.
- Checks CRC_A over the whole frame and emits an AXI-stream-like byte stream with a last flag.

---
 rtl/nfca_rx_frame.sv | 261 ++++++++++++++++++++++++++
 tb/tb_nfca_rx_frame.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nfca_rx_frame.sv
// ---------------------------------------------------------------------------
// nfca_rx_frame
//   Receive-side framer for ISO14443-A PICC->PCD responses.
//
//   It regroups the demodulated LSB-first bit stream into bytes and checks
//   the odd parity bit that follows each complete byte. It handles a short
//   last byte, such as a 4-bit ACK/NAK, and a first byte that completes a
//   PCD anticollision split byte. It also checks CRC_A over the whole frame.
//   Bytes leave as a one-cycle strobe stream with a last flag. There is no
//   backpressure.
//
//   A byte is only known to be the last one when rx_end arrives, so bytes
//   are held back in a small buffer. When rx_end arrives, the buffer is
//   drained one byte per cycle.
//
//   Build option:
//     NFCA_RX_CRC_STRIP_EN -- hold buffer 3 bytes deep. A frame that ends on
//       a byte boundary with a good CRC and at least 3 bytes has its two CRC
//       bytes dropped, and tlast moves onto the last payload byte.
//
//   Ports:
//     clk         system clock
//     rstn        asynchronous active-low reset
//     rx_remainb  valid bits in the PCD's last byte (0 = complete), sampled
//                 at frame start
//     rx_bit_en   strobe: rx_bit valid
//     rx_bit      demodulated bit
//     rx_end      strobe: end of PICC frame
//     rx_tvalid   byte strobe
//     rx_tdata    received byte
//     rx_tdatab   valid bits in rx_tdata (1..8)
//     rx_tlast    last byte of frame
//     rx_tperr    parity error in this byte
//     rx_tcrcok   with rx_tlast: CRC residue zero and >= 3 complete bytes
// ---------------------------------------------------------------------------
module nfca_rx_frame #(
   parameter logic [15:0] CRC_INIT = 16'h6363
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [2:0] rx_remainb,
   input  logic       rx_bit_en,
   input  logic       rx_bit,
   input  logic       rx_end,
   output logic       rx_tvalid,
   output logic [7:0] rx_tdata,
   output logic [3:0] rx_tdatab,
   output logic       rx_tlast,
   output logic       rx_tperr,
   output logic       rx_tcrcok
);

`ifdef NFCA_RX_CRC_STRIP_EN
   localparam int HOLD  = 3;
   localparam bit STRIP = 1'b1;
`else
   localparam int HOLD  = 1;
   localparam bit STRIP = 1'b0;
`endif
   // One slot beyond HOLD: in the rx_end cycle, a freshly completed byte is
   // pushed without displacing the oldest byte, and then everything drains.
   localparam int DEPTH = HOLD + 1;
   localparam int QW    = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] datab;
      logic       perr;
   } ent_t;

   state_t          state_q, state_d;
   logic [2:0]      k0_q, k0_d;
   logic            first_q, first_d;
   logic [7:0]      sh_q, sh_d;
   logic [3:0]      bitcnt_q, bitcnt_d;
   logic [15:0]     crc_q, crc_d;
   logic [11:0]     nbyte_q, nbyte_d;
   ent_t            q_q [DEPTH];
   ent_t            q_d [DEPTH];
   logic [QW-1:0]   qcnt_q, qcnt_d;
   logic [QW-1:0]   dcnt_q, dcnt_d;
   logic            crcok_q, crcok_d;

   logic            tvalid_q, tvalid_d;
   logic [7:0]      tdata_q, tdata_d;
   logic [3:0]      tdatab_q, tdatab_d;
   logic            tlast_q, tlast_d;
   logic            tperr_q, tperr_d;
   logic            tcrcok_q, tcrcok_d;

   ent_t            ent;
   logic [3:0]      tgt;
   logic [2:0]      pos;

   // CRC_A byte step (reflected 0x1021, the same as on the TX side).
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [7:0] ch;
      ch = b ^ c[7:0];
      ch = ch ^ {ch[3:0], 4'h0};
      return {8'h00, c[15:8]} ^ {ch, 8'h00} ^ {5'h00, ch, 3'h0} ^ {12'h000, ch[7:4]};
   endfunction

   always_comb begin
      state_d  = state_q;
      k0_d     = k0_q;
      first_d  = first_q;
      sh_d     = sh_q;
      bitcnt_d = bitcnt_q;
      crc_d    = crc_q;
      nbyte_d  = nbyte_q;
      q_d      = q_q;
      qcnt_d   = qcnt_q;
      dcnt_d   = dcnt_q;
      crcok_d  = crcok_q;
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tdatab_d = '0;
      tlast_d  = 1'b0;
      tperr_d  = 1'b0;
      tcrcok_d = 1'b0;
      ent      = '0;
      pos      = '0;
      // The first byte carries only 8-k0 bits; its low k0 positions are 0.
      tgt      = first_q ? (4'd8 - {1'b0, k0_q}) : 4'd8;

      // End-of-frame drain. Bit strobes are hundreds of clocks apart, so the
      // drain always finishes before the next frame can complete a byte.
      if (dcnt_q != '0) begin
         tvalid_d = 1'b1;
         tdata_d  = q_d[0].data;
         tdatab_d = q_d[0].datab;
         tperr_d  = q_d[0].perr;
         tlast_d  = (dcnt_q == QW'(1));
         tcrcok_d = tlast_d & crcok_q;
         for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_d[i+1];
         q_d[DEPTH-1] = '0;
         qcnt_d = qcnt_d - QW'(1);
         dcnt_d = dcnt_q - QW'(1);
      end

      if (rx_bit_en) begin
         case (state_q)
            IDLE: begin
               k0_d           = rx_remainb;
               first_d        = 1'b1;
               sh_d           = '0;
               sh_d[rx_remainb] = rx_bit;
               bitcnt_d       = 4'd1;
               state_d        = (rx_remainb == 3'd7) ? PARITY : DATA;
            end
            DATA: begin
               pos       = bitcnt_q[2:0] + (first_q ? k0_q : 3'd0);
               sh_d[pos] = rx_bit;
               bitcnt_d  = bitcnt_q + 4'd1;
               if (bitcnt_d == tgt) state_d = PARITY;
            end
            PARITY: begin
               ent.data  = sh_q;
               ent.datab = tgt;
               ent.perr  = (rx_bit != ~^sh_q);
               crc_d     = crc_step(crc_q, sh_q);
               if (nbyte_q != 12'hFFF) nbyte_d = nbyte_q + 12'd1;
               for (int i = 0; i < DEPTH; i++)
                  if (qcnt_d == QW'(i)) q_d[i] = ent;
               qcnt_d = qcnt_d + QW'(1);
               // Buffer overflow: the oldest byte cannot be last any more.
               // With rx_end in the same cycle, the drain below takes everything.
               if (!rx_end && qcnt_d > QW'(HOLD)) begin
                  tvalid_d = 1'b1;
                  tdata_d  = q_d[0].data;
                  tdatab_d = q_d[0].datab;
                  tperr_d  = q_d[0].perr;
                  for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_d[i+1];
                  q_d[DEPTH-1] = '0;
                  qcnt_d = qcnt_d - QW'(1);
               end
               sh_d     = '0;
               bitcnt_d = '0;
               first_d  = 1'b0;
               state_d  = DATA;
            end
            default: ;
         endcase
      end

      // End is evaluated after any same-cycle bit, so an rx_end that
      // coincides with the first bit of a frame still closes that frame.
      if (rx_end && state_d != IDLE) begin
         if (bitcnt_d != '0) begin
            ent.data  = sh_d;
            ent.datab = bitcnt_d;
            ent.perr  = 1'b0;
            for (int i = 0; i < DEPTH; i++)
               if (qcnt_d == QW'(i)) q_d[i] = ent;
            qcnt_d  = qcnt_d + QW'(1);
            crcok_d = 1'b0;
         end else begin
            crcok_d = (crc_d == 16'h0000) && (nbyte_d >= 12'd3);
            // Drop the two newest entries, which are the CRC bytes.
            if (STRIP && crcok_d && qcnt_d >= QW'(3)) qcnt_d = qcnt_d - QW'(2);
         end
         dcnt_d   = qcnt_d;
         state_d  = IDLE;
         crc_d    = CRC_INIT;
         nbyte_d  = '0;
         bitcnt_d = '0;
         sh_d     = '0;
         first_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         k0_q     <= '0;
         first_q  <= 1'b0;
         sh_q     <= '0;
         bitcnt_q <= '0;
         crc_q    <= CRC_INIT;
         nbyte_q  <= '0;
         for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
         qcnt_q   <= '0;
         dcnt_q   <= '0;
         crcok_q  <= 1'b0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tdatab_q <= '0;
         tlast_q  <= 1'b0;
         tperr_q  <= 1'b0;
         tcrcok_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k0_q     <= k0_d;
         first_q  <= first_d;
         sh_q     <= sh_d;
         bitcnt_q <= bitcnt_d;
         crc_q    <= crc_d;
         nbyte_q  <= nbyte_d;
         q_q      <= q_d;
         qcnt_q   <= qcnt_d;
         dcnt_q   <= dcnt_d;
         crcok_q  <= crcok_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tdatab_q <= tdatab_d;
         tlast_q  <= tlast_d;
         tperr_q  <= tperr_d;
         tcrcok_q <= tcrcok_d;
      end
   end

   assign rx_tvalid = tvalid_q;
   assign rx_tdata  = tdata_q;
   assign rx_tdatab = tdatab_q;
   assign rx_tlast  = tlast_q;
   assign rx_tperr  = tperr_q;
   assign rx_tcrcok = tcrcok_q;

endmodule

// File: tb/tb_nfca_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_nfca_rx_frame
//   Directed bench for nfca_rx_frame. Output strobes are captured on the
//   falling edge into a log. Each scenario is then compared against
//   hand-computed bytes.
//   The expectations follow the build: NFCA_RX_CRC_STRIP_EN changes the SAK
//   frame and the non-last latency.
// ---------------------------------------------------------------------------
module tb_nfca_rx_frame;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [2:0] rx_remainb = '0;
   logic       rx_bit_en = 1'b0;
   logic       rx_bit = 1'b0;
   logic       rx_end = 1'b0;
   logic       rx_tvalid;
   logic [7:0] rx_tdata;
   logic [3:0] rx_tdatab;
   logic       rx_tlast, rx_tperr, rx_tcrcok;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_bit_cyc = 0;
   int ncap = 0;
   logic [14:0] cap [64];
   int          cap_cyc [64];

   nfca_rx_frame dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx_remainb (rx_remainb),
      .rx_bit_en  (rx_bit_en),
      .rx_bit     (rx_bit),
      .rx_end     (rx_end),
      .rx_tvalid  (rx_tvalid),
      .rx_tdata   (rx_tdata),
      .rx_tdatab  (rx_tdatab),
      .rx_tlast   (rx_tlast),
      .rx_tperr   (rx_tperr),
      .rx_tcrcok  (rx_tcrcok)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log: {data, datab, last, perr, crcok}
   always @(negedge clk) begin
      if (rx_tvalid) begin
         if (ncap < 64) begin
            cap[ncap]     <= {rx_tdata, rx_tdatab, rx_tlast, rx_tperr, rx_tcrcok};
            cap_cyc[ncap] <= cyc;
         end
         ncap <= ncap + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_strobe(input string tag, input int idx, input logic [7:0] d,
                             input logic [3:0] db, input logic l, input logic pe,
                             input logic ok);
      logic [14:0] obs;
      obs = (idx < 64) ? cap[idx] : 15'bx;
      chk(tag, {17'd0, obs}, {17'd0, d, db, l, pe, ok});
   endtask

   task automatic send_bit(input logic b);
      @(posedge clk); #1 rx_bit_en = 1'b1; rx_bit = b;
      @(posedge clk); #1 rx_bit_en = 1'b0; last_bit_cyc = cyc;
      repeat (2) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] v, input logic p);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      send_bit(p);
   endtask

   task automatic end_frame();
      @(posedge clk); #1 rx_end = 1'b1;
      @(posedge clk); #1 rx_end = 1'b0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      int b;
      int pc;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", {20'd0, rx_tvalid, rx_tdata, rx_tdatab, rx_tlast, rx_tperr, rx_tcrcok}, 32'd0);
      rstn = 1'b1;

      // ATQA 0x44 0x00
      b = ncap;
      send_byte(8'h44, 1'b1);
      send_byte(8'h00, 1'b1);
      pc = last_bit_cyc;
      end_frame();
      chk("atqa_n", ncap - b, 2);
      exp_strobe("atqa_b0", b,     8'h44, 4'd8, 1'b0, 1'b0, 1'b0);
      exp_strobe("atqa_b1", b + 1, 8'h00, 4'd8, 1'b1, 1'b0, 1'b0);
`ifndef NFCA_RX_CRC_STRIP_EN
      chk("atqa_lat", cap_cyc[b], pc);
`endif

      // SAK 0x08 + CRC B6 DD
      b = ncap;
      send_byte(8'h08, 1'b0);
      send_byte(8'hB6, 1'b0);
      send_byte(8'hDD, 1'b1);
      end_frame();
`ifdef NFCA_RX_CRC_STRIP_EN
      chk("sak_n", ncap - b, 1);
      exp_strobe("sak_b0", b, 8'h08, 4'd8, 1'b1, 1'b0, 1'b1);
`else
      chk("sak_n", ncap - b, 3);
      exp_strobe("sak_b0", b,     8'h08, 4'd8, 1'b0, 1'b0, 1'b0);
      exp_strobe("sak_b1", b + 1, 8'hB6, 4'd8, 1'b0, 1'b0, 1'b0);
      exp_strobe("sak_b2", b + 2, 8'hDD, 4'd8, 1'b1, 1'b0, 1'b1);
`endif

      // 4-bit ACK
      b = ncap;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      end_frame();
      chk("ack_n", ncap - b, 1);
      exp_strobe("ack_b0", b, 8'h05, 4'd4, 1'b1, 1'b0, 1'b0);

      // Parity error on the first byte
      b = ncap;
      send_byte(8'h44, 1'b0);
      send_byte(8'h00, 1'b1);
      end_frame();
      chk("perr_n", ncap - b, 2);
      exp_strobe("perr_b0", b,     8'h44, 4'd8, 1'b0, 1'b1, 1'b0);
      exp_strobe("perr_b1", b + 1, 8'h00, 4'd8, 1'b1, 1'b0, 1'b0);

      // SAK with one CRC bit flipped: nothing stripped, crcok low
      b = ncap;
      send_byte(8'h08, 1'b0);
      send_byte(8'hB6, 1'b0);
      send_byte(8'hDC, 1'b0);
      end_frame();
      chk("badcrc_n", ncap - b, 3);
      exp_strobe("badcrc_b0", b,     8'h08, 4'd8, 1'b0, 1'b0, 1'b0);
      exp_strobe("badcrc_b2", b + 2, 8'hDC, 4'd8, 1'b1, 1'b0, 1'b0);

      // Anticollision, k0=3; rx_remainb changes after the first bit
      b = ncap;
      rx_remainb = 3'd3;
      send_bit(1'b1);
      rx_remainb = 3'd0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b0);
      send_byte(8'h12, 1'b1);
      end_frame();
      chk("acol_n", ncap - b, 2);
      exp_strobe("acol_b0", b,     8'h98, 4'd5, 1'b0, 1'b0, 1'b0);
      exp_strobe("acol_b1", b + 1, 8'h12, 4'd8, 1'b1, 1'b0, 1'b0);

      // Last byte with 8 data bits but no parity bit
      b = ncap;
      send_byte(8'h44, 1'b1);
      for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1); // 0x55
      end_frame();
      chk("p8_n", ncap - b, 2);
      exp_strobe("p8_b0", b,     8'h44, 4'd8, 1'b0, 1'b0, 1'b0);
      exp_strobe("p8_b1", b + 1, 8'h55, 4'd8, 1'b1, 1'b0, 1'b0);

      // rx_end with no frame in progress
      b = ncap;
      end_frame();
      chk("empty_n", ncap - b, 0);

      // Reset after 12 bits of a frame
      b = ncap;
      send_byte(8'h44, 1'b1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_out", {20'd0, rx_tvalid, rx_tdata, rx_tdatab, rx_tlast, rx_tperr, rx_tcrcok}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_n", ncap - b, 0);

      b = ncap;
      send_byte(8'h44, 1'b1);
      send_byte(8'h00, 1'b1);
      end_frame();
      chk("atqa2_n", ncap - b, 2);
      exp_strobe("atqa2_b0", b,     8'h44, 4'd8, 1'b0, 1'b0, 1'b0);
      exp_strobe("atqa2_b1", b + 1, 8'h00, 4'd8, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
